// File: rtl/btn_pkg.sv
// Shared definitions for the push-button synchronizer/debouncer: FSM state
// encoding, the board-clock debounce default and the button channel map.
package btn_pkg;

  typedef enum logic [1:0] {
    S_LOW       = 2'b00,
    S_WAIT_HIGH = 2'b01,
    S_HIGH      = 2'b10,
    S_WAIT_LOW  = 2'b11
  } btn_state_t;

  // 10 ms of stability at the 100 MHz board clock
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1000000;

  localparam int unsigned BTN_UP     = 0;
  localparam int unsigned BTN_DOWN   = 1;
  localparam int unsigned BTN_LEFT   = 2;
  localparam int unsigned BTN_RIGHT  = 3;
  localparam int unsigned BTN_CENTER = 4;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: SYNC_STAGES-deep synchronizer feeding a four-state
// debounce FSM with a qualification counter and registered level/busy outputs.
module debounce_channel
  import btn_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_busy
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_i;
  btn_state_t             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
  end

  assign sync_i = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_LOW: begin
        if (sync_i) begin
          state_d = S_WAIT_HIGH;
          cnt_d   = '0;
        end
      end
      S_WAIT_HIGH: begin
        if (!sync_i) begin
          state_d = S_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HIGH: begin
        if (!sync_i) begin
          state_d = S_WAIT_LOW;
          cnt_d   = '0;
        end
      end
      S_WAIT_LOW: begin
        if (sync_i) begin
          state_d = S_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_LOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they move on the same edge as state_q
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_LOW;
      cnt_q     <= '0;
      btn_level <= 1'b0;
      btn_busy  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      btn_level <= (state_d == S_HIGH) || (state_d == S_WAIT_LOW);
      btn_busy  <= (state_d == S_WAIT_HIGH) || (state_d == S_WAIT_LOW);
    end
  end

endmodule

// File: rtl/button_debouncer.sv
// Multi-channel push-button synchronizer/debouncer; one independent
// debounce_channel per button feeding the downstream edge detectors.
module button_debouncer
  import btn_pkg::*;
#(
  parameter int unsigned N_BTN           = 5,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_busy
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .btn_raw   (btn_raw[i]),
      .btn_level (btn_level[i]),
      .btn_busy  (btn_busy[i])
    );
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with DEBOUNCE_CYCLES=4, SYNC_STAGES=2:
// expected level/busy are queued per step and compared after the clock edge.
module tb_button_debouncer;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] btn_raw;
  logic [4:0] btn_level;
  logic [4:0] btn_busy;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    string      tag;
    logic [4:0] lvl;
    logic [4:0] busy;
  } exp_t;

  exp_t sb[$];

  button_debouncer #(
    .N_BTN           (5),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn_raw),
    .btn_level (btn_level),
    .btn_busy  (btn_busy)
  );

  always #5 clk = ~clk;

  task automatic compare_one(input string tag, input logic [4:0] got, input logic [4:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %b, expected %b", tag, got, exp);
  endtask

  task automatic expect_out(input string tag, input logic [4:0] lvl, input logic [4:0] busy);
    exp_t e;
    e.tag  = tag;
    e.lvl  = lvl;
    e.busy = busy;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      $error("FAIL scoreboard_empty: got 0 entries, expected at least 1");
      return;
    end
    e = sb.pop_front();
    compare_one({e.tag, ".level"}, btn_level, e.lvl);
    compare_one({e.tag, ".busy"},  btn_busy,  e.busy);
  endtask

  // Drive raw, queue what the outputs must be after the edge that samples it, then compare
  task automatic cyc(input string tag, input logic [4:0] raw,
                     input logic [4:0] lvl, input logic [4:0] busy);
    btn_raw = raw;
    expect_out(tag, lvl, busy);
    @(posedge clk);
    #1;
    check_out();
  endtask

  // Full qualification of a held change: 2 sync edges, 4 counting edges, accept on the 7th
  task automatic settle(input string tag, input logic [4:0] raw, input logic [4:0] from,
                        input logic [4:0] to, input logic [4:0] mask);
    for (int i = 1; i <= 7; i++) begin
      if (i <= 2)      cyc(tag, raw, from, 5'b00000);
      else if (i <= 6) cyc(tag, raw, from, mask);
      else             cyc(tag, raw, to, 5'b00000);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset asserted before any clock edge: outputs can only be 0 asynchronously
    rst     = 1'b1;
    btn_raw = 5'b11111;
    #2;
    expect_out("reset_async", 5'b00000, 5'b00000);
    check_out();
    @(posedge clk);
    @(posedge clk);
    #1;
    expect_out("reset_held", 5'b00000, 5'b00000);
    check_out();
    rst = 1'b0;
    settle("reset_release", 5'b11111, 5'b00000, 5'b11111, 5'b11111);
    settle("all_release",   5'b00000, 5'b11111, 5'b00000, 5'b11111);

    // Clean press and release on channel 0
    settle("ch0_press", 5'b00001, 5'b00000, 5'b00001, 5'b00001);
    for (int i = 0; i < 2; i++) cyc("ch0_hold", 5'b00001, 5'b00001, 5'b00000);
    settle("ch0_release", 5'b00000, 5'b00001, 5'b00000, 5'b00001);

    // Glitch of 3 cycles on channel 1: busy for 3 cycles, level untouched
    for (int i = 0; i < 8; i++)
      cyc("ch1_glitch3", (i < 3) ? 5'b00010 : 5'b00000, 5'b00000,
          (i >= 2 && i <= 4) ? 5'b00010 : 5'b00000);

    // Excursion of exactly DEBOUNCE_CYCLES is still rejected
    for (int i = 0; i < 8; i++)
      cyc("ch1_glitch4", (i < 4) ? 5'b00010 : 5'b00000, 5'b00000,
          (i >= 2 && i <= 5) ? 5'b00010 : 5'b00000);

    // Bounce on release of channel 2: 1,0,1,0 then hold 0
    settle("ch2_press", 5'b00100, 5'b00000, 5'b00100, 5'b00100);
    for (int i = 0; i < 11; i++)
      cyc("ch2_bounce", (i == 0 || i == 2) ? 5'b00100 : 5'b00000,
          (i <= 8) ? 5'b00100 : 5'b00000,
          (i == 3 || (i >= 5 && i <= 8)) ? 5'b00100 : 5'b00000);

    // Channel 3 reset while qualifying with cnt = 2
    for (int i = 0; i < 5; i++)
      cyc("ch3_qual", 5'b01000, 5'b00000, (i >= 2) ? 5'b01000 : 5'b00000);
    #2;
    rst = 1'b1;
    #1;
    expect_out("ch3_rst_async", 5'b00000, 5'b00000);
    check_out();
    @(posedge clk);
    #1;
    expect_out("ch3_rst_held", 5'b00000, 5'b00000);
    check_out();
    rst = 1'b0;
    settle("ch3_requal",  5'b01000, 5'b00000, 5'b01000, 5'b01000);
    settle("ch3_release", 5'b00000, 5'b01000, 5'b00000, 5'b01000);

    // Simultaneous press on channels 0 and 4
    settle("ch04_press",   5'b10001, 5'b00000, 5'b10001, 5'b10001);
    settle("ch04_release", 5'b00000, 5'b10001, 5'b00000, 5'b10001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
Multi-channel synchronizer and debouncer for the board push-buttons. It sits directly upstream of the rising-edge pulse generators in the sliding-text display. Raw asynchronous button pins enter through a synchronizer chain. Each channel's clean, glitch-free level goes to the edge detectors, which turn presses into single-cycle scroll/speed/mode commands.

Parameters:
N_BTN, 5, number of independent button channels
SYNC_STAGES, 2, flip-flops in each input synchronizer chain (legal: >= 2)
DEBOUNCE_CYCLES, 1000000, consecutive stable synchronized cycles needed to accept a new level (10 ms at 100 MHz; legal: >= 1)

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  reset, asynchronous, active-high
btn_raw  input  N_BTN  raw asynchronous button pins, bit i = channel i
btn_level  output  N_BTN  debounced level per channel, registered
btn_busy  output  N_BTN  1 while channel i is qualifying a candidate change

Behaviour:
- Reset is asynchronous and active-high on rst; clock is clk.
- While rst=1, all of the following hold: synchronizer flops = 0, all channels in S_LOW, counters = 0, btn_level = 0, btn_busy = 0.
- Synchronizer: per channel, SYNC_STAGES-deep shift chain; sync_i is the last stage. Only the first stage samples btn_raw.
- Per-channel Moore FSM with states S_LOW, S_WAIT_HIGH, S_HIGH, S_WAIT_LOW.
- S_LOW: if sync_i = 1, go to S_WAIT_HIGH and clear cnt; otherwise stay.
- S_WAIT_HIGH:
  - if sync_i = 0, go to S_LOW and clear cnt;
  - else if cnt = DEBOUNCE_CYCLES-1, go to S_HIGH and clear cnt;
  - else cnt = cnt + 1.
- S_HIGH: if sync_i = 0, go to S_WAIT_LOW and clear cnt; otherwise stay.
- S_WAIT_LOW: mirror of S_WAIT_HIGH with polarities swapped.
  - if sync_i = 1, return to S_HIGH;
  - else at cnt = DEBOUNCE_CYCLES-1, go to S_LOW.
- Illegal state encodings go to S_LOW on the next edge.
- Outputs:
  - btn_level = 1 in S_HIGH and S_WAIT_LOW; 0 otherwise.
  - btn_busy = 1 in S_WAIT_HIGH and S_WAIT_LOW.
  - Both are decoded from registered state only, with no combinational path from btn_raw.
- Latency: count from the first clk edge that samples the new btn_raw value. If the new value is held steady, btn_level changes after exactly SYNC_STAGES + 1 + DEBOUNCE_CYCLES edges (defaults: 1000003).
- Glitch rejection: any synchronized excursion lasting DEBOUNCE_CYCLES or fewer cycles leaves btn_level unchanged. btn_busy pulses for the duration of the excursion.
- Counter: width $clog2(DEBOUNCE_CYCLES+1). It is cleared on every state change and never wraps; the terminal compare fires before overflow.
- Channels are fully independent. Simultaneous presses on several channels qualify in parallel with identical latency.
- Reset during qualification: the channel is abandoned and returns to S_LOW with btn_level = 0. If the button is still held after rst falls, it must requalify with the full latency.
- DEBOUNCE_CYCLES = 1: a new level is accepted after a single stable cycle in the wait state.

Decomposition:
- Shared package btn_pkg holds:
  - the 2-bit state encoding constants S_LOW=00, S_WAIT_HIGH=01, S_HIGH=10, S_WAIT_LOW=11;
  - the default DEBOUNCE_CYCLES for the 100 MHz board clock;
  - button index constants BTN_UP, BTN_DOWN, BTN_LEFT, BTN_RIGHT, BTN_CENTER (0..4).
- One sub-module, debounce_channel: single-bit synchronizer + FSM + counter. It is instantiated N_BTN times by a generate loop in button_debouncer.

Test Plan:
All tests use DEBOUNCE_CYCLES=4, SYNC_STAGES=2, N_BTN=5.
- Reset: assert rst with btn_raw=5'b11111 -> btn_level=0 and btn_busy=0 immediately (asynchronous); outputs stay 0 for 6 edges after release, then bits 0..4 rise on the 7th edge.
- Clean press on ch0: btn_raw[0] 0->1 held -> btn_busy[0]=1 for 4 cycles; btn_level[0] rises exactly 7 edges after first sampling; other bits stay 0.
- Glitch rejection: btn_raw[1] high for 3 cycles, then low -> btn_level[1] stays 0; btn_busy[1] pulses, then returns to 0.
- Bounce on release: ch2 stable high, then toggle 1,0,1,0 each cycle, then hold 0 -> btn_level[2] stays 1 through the bounce and falls 7 edges after the final 1->0 sample.
- Reset mid-qualification: rst pulsed while ch3 is in S_WAIT_HIGH with cnt=2 -> btn_level[3]=0; with the button still held after release, the full 7-edge latency is required.
- Simultaneous: channels 0 and 4 pressed on the same edge -> both btn_level bits rise on the same cycle, 7 edges later.
